spi_slave_regfile: RTL and testbench

//  Parametrised SPI (mode 0) slave and register file, oversampled in the system clock domain.

---
 rtl/spi_regfile_pkg.sv | 33 +++
 rtl/spi_sync_edge.sv | 46 ++++
 rtl/spi_slave_regfile.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and sizing helpers for the SPI slave register file.
//   state_e   : frame FSM states
//   frame_len : frame length in bits, excluding the optional parity bit
//   PAR_W     : 1 when SPI_PARITY_EN is defined (trailing even-parity bit), else 0
package spi_regfile_pkg;

  localparam int unsigned DEF_CH_W   = 2;
  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DEPTH  = 10;
  localparam int unsigned DEF_DATA_W = 22;

`ifdef SPI_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  // R/W bit + channel + address + data
  function automatic int unsigned frame_len(input int unsigned ch_w,
                                            input int unsigned addr_w,
                                            input int unsigned data_w);
    return 1 + ch_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchroniser with registered rise/fall strobes for an asynchronous input.
// Ports:
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_d          : asynchronous input
//   o_q          : synchronised level
//   o_rise/o_fall: 1-clk strobes on a synchronised 0->1 / 1->0 transition
// RST_VAL sets the idle level the chain resets to, so reset never produces a strobe.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  // synchroniser chain and edge strobes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_q    = r_sync;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a NUM_CH x DEPTH x DATA_W register file, oversampled in clk.
// Frame (MSB first): R/W (1=read), channel, address, data [, even parity].
// Optional feature macro: SPI_PARITY_EN (adds a trailing even-parity bit).
// Ports:
//   i_clk, i_rst         : system clock (>= 4x sclk), synchronous active-high reset
//   i_sclk, i_cs_n, i_mosi: asynchronous SPI pins
//   o_miso, o_miso_oe    : SPI data out and its drive enable
//   o_wr_valid/_ch/_addr/_data : 1-clk pulse and fields of a committed SPI write
//   o_frame_err          : 1-clk pulse when a frame is rejected
//   i_rd_ch, i_rd_addr, o_rd_data : host read port, 1-clk latency, 0 when out of range
module spi_slave_regfile
  import spi_regfile_pkg::*;
#(
  parameter int unsigned CH_W   = DEF_CH_W,
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic              o_wr_valid,
  output logic [CH_W-1:0]   o_wr_ch,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_frame_err,
  input  logic [CH_W-1:0]   i_rd_ch,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned HDR_W   = 1 + CH_W + ADDR_W;
  localparam int unsigned FLEN    = frame_len(CH_W, ADDR_W, DATA_W) + PAR_W;
  localparam int unsigned CNT_W   = $clog2(FLEN + 2);
  localparam int unsigned ENTRIES = NUM_CH * DEPTH;
  localparam int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_unused_sclk_q;

  logic r_mosi_meta, r_mosi_sync;

  state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [HDR_W-1:0]  r_hdr;
  logic [DATA_W-1:0] r_wsr;
  logic [DATA_W:0]   r_shadow;
  logic              r_par;
  logic              r_miso, r_miso_oe;
  logic              r_wr_valid, r_frame_err;
  logic [CH_W-1:0]   r_wr_ch;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [ENTRIES];

  logic              w_rw;
  logic [CH_W-1:0]   w_ch;
  logic [ADDR_W-1:0] w_addr;
  logic              w_hdr_ok, w_rd_ok;
  logic [IDX_W-1:0]  w_hdr_idx, w_rd_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_hdr_done, w_full, w_short, w_par_ok;
  logic              w_frame_start, w_wr_ok, w_err;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_sclk),
    .o_q    (w_sclk_q),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_cs_n),
    .o_q    (w_cs_q),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // only the sclk edges matter; its level is intentionally unused
  assign w_unused_sclk_q = w_sclk_q;

  // header fields and range checks
  assign w_rw      = r_hdr[HDR_W-1];
  assign w_ch      = r_hdr[HDR_W-2 -: CH_W];
  assign w_addr    = r_hdr[ADDR_W-1:0];
  assign w_hdr_ok  = (32'(w_ch) < NUM_CH) && (32'(w_addr) < DEPTH);
  assign w_hdr_idx = IDX_W'(32'(w_ch) * DEPTH + 32'(w_addr));
  assign w_rd_ok   = (32'(i_rd_ch) < NUM_CH) && (32'(i_rd_addr) < DEPTH);
  assign w_rd_idx  = IDX_W'(32'(i_rd_ch) * DEPTH + 32'(i_rd_addr));
  assign w_rd_word = w_hdr_ok ? r_mem[w_hdr_idx] : '0;

  assign w_hdr_done    = (r_state == HDR) && (r_cnt == CNT_W'(HDR_W));
  assign w_full        = (r_cnt == CNT_W'(FLEN));
  assign w_short       = (r_cnt <  CNT_W'(FLEN));
  assign w_par_ok      = (PAR_W == 0) || !r_par;
  assign w_frame_start = (r_state == IDLE) && w_cs_fall && !w_cs_q;

  // commit decision, evaluated on the clk after synced cs_n rises
  always_comb begin
    w_wr_ok = 1'b0;
    w_err   = 1'b0;
    if (w_cs_rise) begin
      if (w_rw) begin
        w_err = w_short || !w_hdr_ok;
      end else begin
        w_wr_ok = w_full && w_hdr_ok && w_par_ok;
        w_err   = !w_wr_ok;
      end
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state; a deselected bus always aborts to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_q) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_cs_fall)  w_state_nxt = HDR;
        HDR:     if (w_hdr_done) w_state_nxt = DATA;
        DATA:    if (w_full)     w_state_nxt = DONE;
        DONE:    w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // SPI shift path: counter, header/data capture, parity, MISO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_cnt       <= '0;
      r_hdr       <= '0;
      r_wsr       <= '0;
      r_par       <= 1'b0;
      r_shadow    <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
    end else begin
      r_mosi_meta <= i_mosi;
      r_mosi_sync <= r_mosi_meta;
      r_miso_oe   <= ~w_cs_q;

      if (w_frame_start) begin
        r_cnt <= '0;
        r_hdr <= '0;
        r_wsr <= '0;
        r_par <= 1'b0;
      end else if (w_sclk_rise && (r_state != IDLE)) begin
        if (r_cnt != CNT_W'(FLEN + 1)) r_cnt <= r_cnt + CNT_W'(1);
        if (r_state == HDR) begin
          r_hdr <= {r_hdr[HDR_W-2:0], r_mosi_sync};
          r_par <= r_par ^ r_mosi_sync;
        end else if (r_state == DATA) begin
          r_par <= r_par ^ r_mosi_sync;
          // the trailing parity bit is folded into r_par but not into the data word
          if (r_cnt < CNT_W'(HDR_W + DATA_W)) r_wsr <= {r_wsr[DATA_W-2:0], r_mosi_sync};
        end
      end

      // shadow carries the data plus its parity; parity only shifts out when enabled
      if (w_hdr_done) begin
        r_shadow <= {w_rd_word, ^w_rd_word};
      end else if (w_sclk_fall && (r_state == DATA) && w_rw) begin
        r_shadow <= {r_shadow[DATA_W-1:0], 1'b0};
      end

      if ((r_state == DATA) && w_rw) begin
        if (w_sclk_fall) r_miso <= r_shadow[DATA_W];
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  // register file, write commit and host read (read-before-write via NBA)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_mem[i] <= '0;
      r_wr_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_ch     <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_data   <= '0;
    end else begin
      r_wr_valid  <= w_wr_ok;
      r_frame_err <= w_err;
      if (w_wr_ok) begin
        r_mem[w_hdr_idx] <= r_wsr;
        r_wr_ch          <= w_ch;
        r_wr_addr        <= w_addr;
        r_wr_data        <= r_wsr;
      end
      r_rd_data <= w_rd_ok ? r_mem[w_rd_idx] : '0;
    end
  end

  assign o_miso      = r_miso;
  assign o_miso_oe   = r_miso_oe;
  assign o_wr_valid  = r_wr_valid;
  assign o_wr_ch     = r_wr_ch;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_frame_err = r_frame_err;
  assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: SPI master tasks, write scoreboard, host read checks.
module tb_spi_slave_regfile;

  localparam int HALF = 8;
`ifdef SPI_PARITY_EN
  localparam int PAR  = 1;
`else
  localparam int PAR  = 0;
`endif
  localparam int FLEN = 33 + PAR;

  typedef struct packed {
    logic [1:0]  ch;
    logic [7:0]  addr;
    logic [21:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, sclk, cs_n, mosi;
  logic        miso, miso_oe, wr_valid, frame_err;
  logic [1:0]  wr_ch, rd_ch;
  logic [7:0]  wr_addr, rd_addr;
  logic [21:0] wr_data, rd_data;

  int  checks   = 0;
  int  failures = 0;
  int  err_cnt  = 0;
  int  wr_cnt   = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  spi_slave_regfile dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sclk      (sclk),
    .i_cs_n      (cs_n),
    .i_mosi      (mosi),
    .o_miso      (miso),
    .o_miso_oe   (miso_oe),
    .o_wr_valid  (wr_valid),
    .o_wr_ch     (wr_ch),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_frame_err (frame_err),
    .i_rd_ch     (rd_ch),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // write scoreboard and frame_err counter
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (wr_valid === 1'b1) begin
      wr_t e;
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL unexpected_wr observed=%0h expected=none", {wr_ch, wr_addr, wr_data});
      end else begin
        e = exp_q.pop_front();
        assert ({wr_ch, wr_addr, wr_data} === e) else begin
          failures++;
          $error("FAIL wr_fields observed=%0h expected=%0h", {wr_ch, wr_addr, wr_data}, e);
        end
      end
    end
  end

  function automatic logic [63:0] mk_frame(input logic rw, input logic [1:0] ch,
                                           input logic [7:0] addr, input logic [21:0] d);
    logic [63:0] f;
    f = 64'({rw, ch, addr, d});
`ifdef SPI_PARITY_EN
    f = {f[62:0], ^f};
`endif
    return f;
  endfunction

  // mode-0 master: MOSI set while sclk low, MISO sampled just before each rise
  task automatic spi_xfer(input logic [63:0] bits, input int n, input int rst_at,
                          output logic [63:0] rx, output logic oe_ok);
    rx    = '0;
    oe_ok = 1'b1;
    cs_n  = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      mosi = bits[n-1-i];
      repeat (HALF) @(negedge clk);
      if (miso_oe !== 1'b1) oe_ok = 1'b0;
      rx   = {rx[62:0], miso};
      sclk = 1'b1;
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic host_rd(input logic [1:0] ch, input logic [7:0] addr, output logic [21:0] d);
    rd_ch   = ch;
    rd_addr = addr;
    repeat (2) @(negedge clk);
    d = rd_data;
  endtask

  initial begin
    logic [63:0] f, rx;
    logic        oe_ok;
    logic [21:0] d;
    int          e0, w0;

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; rd_ch = '0; rd_addr = '0;
    repeat (4) @(negedge clk);
    check("rst_miso", 64'(miso), 0);
    check("rst_miso_oe", 64'(miso_oe), 0);
    check("rst_wr_valid", 64'(wr_valid), 0);
    check("rst_frame_err", 64'(frame_err), 0);
    check("rst_rd_data", 64'(rd_data), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // write ch1 addr3
    e0 = err_cnt;
    exp_q.push_back('{ch: 2'd1, addr: 8'd3, data: 22'h26d53e});
    spi_xfer(mk_frame(1'b0, 2'd1, 8'd3, 22'h26d53e), FLEN, -1, rx, oe_ok);
    check("wr1_drained", 64'(exp_q.size()), 0);
    check("wr1_count", 64'(wr_cnt), 1);
    check("wr1_no_err", 64'(err_cnt), 64'(e0));
    host_rd(2'd1, 8'd3, d);
    check("host_rd_1_3", 64'(d), 64'h26d53e);

    // read ch1 addr3 over SPI
    spi_xfer(mk_frame(1'b1, 2'd1, 8'd3, 22'h0), FLEN, -1, rx, oe_ok);
    check("spi_rd_1_3", 64'(rx[PAR +: 22]), 64'h26d53e);
`ifdef SPI_PARITY_EN
    check("spi_rd_par", 64'(rx[0]), 64'(^22'h26d53e));
`endif
    check("oe_during_frame", 64'(oe_ok), 1);
    check("oe_after_frame", 64'(miso_oe), 0);
    check("rd_no_err", 64'(err_cnt), 64'(e0));
    check("rd_no_wr", 64'(wr_cnt), 1);

    // boundary entry ch3 addr9 write and SPI readback
    exp_q.push_back('{ch: 2'd3, addr: 8'd9, data: 22'h155aaa});
    spi_xfer(mk_frame(1'b0, 2'd3, 8'd9, 22'h155aaa), FLEN, -1, rx, oe_ok);
    check("wr2_drained", 64'(exp_q.size()), 0);
    spi_xfer(mk_frame(1'b1, 2'd3, 8'd9, 22'h0), FLEN, -1, rx, oe_ok);
    check("spi_rd_3_9", 64'(rx[PAR +: 22]), 64'h155aaa);

    // out-of-range address write and read
    e0 = err_cnt; w0 = wr_cnt;
    spi_xfer(mk_frame(1'b0, 2'd1, 8'd10, 22'h3fffff), FLEN, -1, rx, oe_ok);
    check("oor_wr_err", 64'(err_cnt), 64'(e0 + 1));
    check("oor_wr_no_valid", 64'(wr_cnt), 64'(w0));
    host_rd(2'd1, 8'd10, d);
    check("host_rd_oor", 64'(d), 0);
    host_rd(2'd1, 8'd3, d);
    check("oor_unchanged_1_3", 64'(d), 64'h26d53e);
    spi_xfer(mk_frame(1'b1, 2'd1, 8'd10, 22'h0), FLEN, -1, rx, oe_ok);
    check("oor_rd_err", 64'(err_cnt), 64'(e0 + 2));
    check("oor_rd_zero", 64'(rx[PAR +: 22]), 0);

    // short (20 bits) and long (FLEN+1 bits) write frames
    f = mk_frame(1'b0, 2'd2, 8'd5, 22'h2aaaaa);
    spi_xfer(f >> (FLEN - 20), 20, -1, rx, oe_ok);
    check("short_err", 64'(err_cnt), 64'(e0 + 3));
    spi_xfer({f[62:0], 1'b1}, FLEN + 1, -1, rx, oe_ok);
    check("long_err", 64'(err_cnt), 64'(e0 + 4));
    check("short_long_no_valid", 64'(wr_cnt), 64'(w0));
    host_rd(2'd2, 8'd5, d);
    check("short_long_unchanged", 64'(d), 0);

    // reset mid-frame, then a clean write
    w0 = wr_cnt;
    spi_xfer(mk_frame(1'b0, 2'd2, 8'd4, 22'h012345), FLEN, 15, rx, oe_ok);
    exp_q.push_back('{ch: 2'd0, addr: 8'd0, data: 22'h000003});
    spi_xfer(mk_frame(1'b0, 2'd0, 8'd0, 22'h000003), FLEN, -1, rx, oe_ok);
    check("post_rst_drained", 64'(exp_q.size()), 0);
    check("post_rst_one_wr", 64'(wr_cnt), 64'(w0 + 1));
    host_rd(2'd2, 8'd4, d);
    check("aborted_not_written", 64'(d), 0);
    host_rd(2'd0, 8'd0, d);
    check("clean_wr_0_0", 64'(d), 64'h3);
    host_rd(2'd1, 8'd3, d);
    check("rst_cleared_1_3", 64'(d), 0);

`ifdef SPI_PARITY_EN
    // correct parity commits, flipped parity is rejected
    exp_q.push_back('{ch: 2'd1, addr: 8'd7, data: 22'h0abcde});
    spi_xfer(mk_frame(1'b0, 2'd1, 8'd7, 22'h0abcde), FLEN, -1, rx, oe_ok);
    check("par_ok_drained", 64'(exp_q.size()), 0);
    e0 = err_cnt; w0 = wr_cnt;
    spi_xfer(mk_frame(1'b0, 2'd1, 8'd7, 22'h111111) ^ 64'd1, FLEN, -1, rx, oe_ok);
    check("par_bad_err", 64'(err_cnt), 64'(e0 + 1));
    check("par_bad_no_valid", 64'(wr_cnt), 64'(w0));
    host_rd(2'd1, 8'd7, d);
    check("par_bad_unchanged", 64'(d), 64'h0abcde);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
